// File: rtl/freq_meter_gated.sv
// Gated frequency meter: counts selected edges of an asynchronous input over a
// fixed window of WINDOW clocks, latches a saturating count, converts it to a
// decile digit of FULL_SCALE with a sequential comparator, and drives seg7.
// Constraints: WINDOW >= 16, SYNC_STAGES >= 2, 10 <= FULL_SCALE <= MAX_COUNT.

// Seven-segment decoder, segments ordered {g,f,e,d,c,b,a}, active high.
module seg7 (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Digit-to-segment lookup; codes above 9 blank the display.
  always_comb begin
    seg_o = 7'h00;
    case (digit_i)
      4'd0:    seg_o = 7'h3F;
      4'd1:    seg_o = 7'h06;
      4'd2:    seg_o = 7'h5B;
      4'd3:    seg_o = 7'h4F;
      4'd4:    seg_o = 7'h66;
      4'd5:    seg_o = 7'h6D;
      4'd6:    seg_o = 7'h7D;
      4'd7:    seg_o = 7'h07;
      4'd8:    seg_o = 7'h7F;
      4'd9:    seg_o = 7'h6F;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

module freq_meter_gated #(
  parameter  int WINDOW      = 1000,
  parameter  int MAX_COUNT   = 500,
  parameter  int FULL_SCALE  = 500,
  parameter  int SYNC_STAGES = 2,
  localparam int CW          = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sig_i,
  input  logic [1:0]    mode_i,
  input  logic          hold_i,
  output logic [CW-1:0] count_o,
  output logic          count_valid_o,
  output logic          ovf_o,
  output logic [3:0]    digit_o,
  output logic          digit_valid_o,
  output logic [6:0]    segments_o
);

  localparam int WW = $clog2(WINDOW);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_DONE} state_t;

  // Saturating increment of the window edge count.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    if (!inc) return v;
    if (v >= CW'(MAX_COUNT)) return CW'(MAX_COUNT);
    return v + CW'(1);
  endfunction

  // Decile thresholds T_k = ceil(k*FULL_SCALE/10), k = 1..9 at index k-1.
  logic [CW-1:0] thr_tab [0:8];
  for (genvar g = 0; g < 9; g++) begin : g_thr
    assign thr_tab[g] = CW'(((g + 1) * FULL_SCALE + 9) / 10);
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic                   rise, fall, edge_hit;
  logic [WW-1:0]          win_cnt_q, win_cnt_d;
  logic                   win_last;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_next;
  logic                   close_vld_q, close_vld_d;
  logic [CW-1:0]          close_cnt_q, close_cnt_d;
  logic                   close_ovf_q, close_ovf_d;
  logic                   capture;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   count_valid_q, count_valid_d;
  state_t                 state_q, state_d;
  logic [3:0]             kidx_q, kidx_d;
  logic [3:0]             acc_q, acc_d;
  logic [3:0]             digit_q, digit_d;
  logic                   digit_valid_q, digit_valid_d;
  logic                   above;

  // Edge qualification on the synchronised input; mode 11 disables counting.
  always_comb begin
    rise     = sync_q[SYNC_STAGES-1] & ~dly_q;
    fall     = ~sync_q[SYNC_STAGES-1] & dly_q;
    edge_hit = 1'b0;
    case (mode_i)
      2'b00:   edge_hit = rise;
      2'b01:   edge_hit = fall;
      2'b10:   edge_hit = rise | fall;
      default: edge_hit = 1'b0;
    endcase
  end

  // Synchroniser, window timing and per-window counting. The count never
  // decreases inside a window, so "an increment was suppressed" and "the count
  // reached MAX_COUNT" both reduce to the closing value being MAX_COUNT.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], sig_i};
    dly_d       = sync_q[SYNC_STAGES-1];
    cnt_next    = sat_inc(cnt_q, edge_hit);
    win_last    = (win_cnt_q == WW'(WINDOW - 1));
    win_cnt_d   = win_last ? '0 : win_cnt_q + WW'(1);
    cnt_d       = win_last ? '0 : cnt_next;
    close_vld_d = win_last;
    close_cnt_d = win_last ? cnt_next : close_cnt_q;
    close_ovf_d = win_last ? (cnt_next == CW'(MAX_COUNT)) : close_ovf_q;
  end

  // Front-end registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      dly_q       <= 1'b0;
      win_cnt_q   <= '0;
      cnt_q       <= '0;
      close_vld_q <= 1'b0;
      close_cnt_q <= '0;
      close_ovf_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      dly_q       <= dly_d;
      win_cnt_q   <= win_cnt_d;
      cnt_q       <= cnt_d;
      close_vld_q <= close_vld_d;
      close_cnt_q <= close_cnt_d;
      close_ovf_q <= close_ovf_d;
    end
  end

  // Output capture one cycle after window close, suppressed while holding.
  always_comb begin
    capture       = close_vld_q & ~hold_i;
    count_d       = capture ? close_cnt_q : count_q;
    ovf_d         = capture ? close_ovf_q : ovf_q;
    count_valid_d = capture;
  end

  // Capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      ovf_q         <= 1'b0;
      count_valid_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      count_valid_q <= count_valid_d;
    end
  end

  // Conversion FSM: enters CMP together with the capture so that threshold
  // k=1 is tested in the count_valid cycle; digit_valid lands ten cycles later.
  always_comb begin
    state_d       = state_q;
    kidx_d        = kidx_q;
    acc_d         = acc_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    above         = (count_q > thr_tab[kidx_q]);
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          state_d = S_CMP;
          kidx_d  = '0;
          acc_d   = '0;
        end
      end
      S_CMP: begin
        acc_d = acc_q + {3'b000, above};
        if (kidx_q == 4'd8) begin
          state_d = S_DONE;
        end else begin
          kidx_d = kidx_q + 4'd1;
        end
      end
      S_DONE: begin
        digit_d       = acc_q;
        digit_valid_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Conversion registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      kidx_q        <= '0;
      acc_q         <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kidx_q        <= kidx_d;
      acc_q         <= acc_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
    end
  end

  seg7 u_seg7 (
    .digit_i (digit_q),
    .seg_o   (segments_o)
  );

  assign count_o       = count_q;
  assign ovf_o         = ovf_q;
  assign count_valid_o = count_valid_q;
  assign digit_o       = digit_q;
  assign digit_valid_o = digit_valid_q;

endmodule

// File: doc/freq_meter_gated.md
Name: freq_meter_gated

Overview:
- Parametrised successor to the moving-average frequency display.
- Counts selected edges of an asynchronous input over a fixed gate window of WINDOW clocks, then latches a saturating count per window.
- A sequential comparator FSM converts each latched count into a decile digit 0..9 of FULL_SCALE, which drives the team's existing seg7 decoder.
- Sits between the io_in pin mux and the 7-segment display; also exports the raw count.

Parameters:
- WINDOW, 1000, gate window length in clk cycles; must be >= 16.
- MAX_COUNT, 500, saturation value of the per-window edge count.
- FULL_SCALE, 500, count mapped to digit boundary 10; requires 10 <= FULL_SCALE <= MAX_COUNT.
- SYNC_STAGES, 2, synchroniser flops on sig_i; must be >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- sig_i  in  1  asynchronous signal under measurement
- mode_i  in  2  edge select: 00 rising, 01 falling, 10 both, 11 none (counting disabled)
- hold_i  in  1  freeze outputs; measurement continues
- count_o  out  CW  latched window count, CW = $clog2(MAX_COUNT+1)
- count_valid_o  out  1  one-cycle pulse when count_o updates
- ovf_o  out  1  latched window saturated
- digit_o  out  4  decile digit 0..9
- digit_valid_o  out  1  one-cycle pulse when digit_o updates
- segments_o  out  7  seg7 decode of digit_o

Behaviour:
- Reset:
  - All outputs 0; segments_o shows "0".
  - Window counter, edge counter, synchroniser and conversion FSM all cleared.
  - Reset mid-window or mid-conversion aborts it; no valid pulse follows.
- Synchroniser and edge detect:
  - sig_i passes through SYNC_STAGES flops, then one delay flop for edge detect.
  - An edge on sig_i enters the edge counter SYNC_STAGES+1 cycles later.
- Mode:
  - mode_i is sampled every cycle; a change takes effect immediately.
- Window:
  - win_cnt runs 0..WINDOW-1 and wraps.
  - In the cycle win_cnt == WINDOW-1, the edge detected that cycle belongs to the closing window.
  - Closing value: cnt_next = min(cnt + edge, MAX_COUNT). cnt clears to 0 for the next window.
- Saturation:
  - cnt never exceeds MAX_COUNT.
  - A window sets its ovf flag if any increment was suppressed or the count reached MAX_COUNT.
- Capture, one cycle after window end:
  - If hold_i == 0: count_o <= cnt_next, ovf_o <= window ovf, count_valid_o pulses, and conversion starts.
  - If hold_i == 1: outputs unchanged, no pulse, no conversion. The window still restarts.
- Conversion FSM, states IDLE -> CMP -> DONE -> IDLE:
  - Thresholds T_k = ceil(k*FULL_SCALE/10) for k = 1..9, computed at elaboration as integer constants.
  - CMP evaluates one k per cycle (k = 1..9, 9 cycles), accumulating digit = count of k with count_o > T_k.
  - DONE: digit_o updates and digit_valid_o pulses.
  - With count_valid_o high in cycle C, digit_valid_o is high in cycle C+10.
  - Equality is not exceeding: count == T_k does not advance the digit.
  - WINDOW >= 16 guarantees conversion finishes before the next capture; no capture ever preempts a conversion.
- segments_o is combinational from digit_o via an instance of the existing seg7.
- Widths:
  - win_cnt is $clog2(WINDOW) bits.
  - All comparisons are unsigned at width CW.

Test Plan:
- Rising edges: WINDOW=100, FULL_SCALE=50, MAX_COUNT=63, mode 00, sig period 4 cycles, checked from the 2nd window on -> count_o=25, ovf_o=0, digit_o=4 (25 == T_5 is not counted), digit_valid_o exactly 10 cycles after count_valid_o.
- Both edges: same stimulus, mode 10 -> count_o=50, digit_o=9. Falling edges: mode 01 -> count_o=25.
- Saturation: sig toggling every cycle, mode 10 -> count_o=63, ovf_o=1, digit_o=9. Next window with mode 11 -> count_o=0, ovf_o=0, digit_o=0, segments_o = "0" pattern.
- Hold: hold_i high across two window ends -> no count_valid_o or digit_valid_o pulses, outputs frozen. hold_i low -> next capture reflects only the latest window.
- Reset mid-conversion: assert reset 3 cycles after count_valid_o -> no digit_valid_o pulse, all outputs 0 next cycle. First capture occurs WINDOW+1 cycles after reset deasserts.
- Threshold sweep: inject exact per-window counts 5, 6, 45, 46 (FULL_SCALE=50) -> digit_o = 0, 1, 8, 9.
